// File: rtl/filter_sched_pkg.sv
// Shared mode encodings, FSM states and default timing constants for the
// sketch/cartoon filter output sequencer.
package filter_sched_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_SKETCH  = 2'd1,
        MODE_CARTOON = 2'd2,
        MODE_SPLIT   = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam int unsigned DEF_PIPE_DLY = 12;
    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_V_ACTIVE = 768;

    // Advance order wraps SPLIT back to PASS.
    function automatic mode_t mode_succ(input mode_t m);
        logic [1:0] nxt;
        nxt = m + 2'd1;
        return mode_t'(nxt);
    endfunction

endpackage

// File: rtl/filter_sched_delay_line.sv
// N-stage register shift line with asynchronous reset to a per-bit reset value.
module delay_line #(
    parameter int unsigned W       = 8,
    parameter int unsigned N       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) sr[i] <= RST_VAL;
        end else begin
            sr[0] <= d;
            for (int unsigned i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/filter_sched.sv
// Mode controller and output sequencer: frame-boundary mode commit, datapath
// latency matching, border masking and the registered VGA-side outputs.
module filter_sched
    import filter_sched_pkg::*;
#(
    parameter int unsigned PIPE_DLY   = DEF_PIPE_DLY,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter logic [1:0]  RESET_MODE = MODE_CARTOON
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [23:0] rgb_in,
    input  logic [23:0] rgb_edge,
    input  logic [23:0] rgb_cartoon,
    input  logic        mode_next,
    input  logic        sel_valid,
    input  logic [1:0]  sel_mode,
    output logic [23:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic [1:0]  mode,
    output logic        pending
);

    localparam int unsigned DW = 24 + 11 + 10 + 3;

    logic [DW-1:0] dly_in, dly_q;
    logic [23:0]   rgb_d, edge_r, cart_r, rgb_sel;
    logic [10:0]   hcount_d;
    logic [9:0]    vcount_d;
    logic          hsync_d, vsync_d, blank_d;
    logic          commit, req, border;
    state_t        state_q, state_n;
    mode_t         mode_q, mode_n, target_q, target_n, req_mode;

    assign dly_in = {rgb_in, hcount, vcount, hsync, vsync, blank};

    // Blank is the LSB, so its stages reset to 1 while everything else clears.
    delay_line #(
        .W       (DW),
        .N       (PIPE_DLY),
        .RST_VAL (48'h1)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (dly_in),
        .q   (dly_q)
    );

    assign {rgb_d, hcount_d, vcount_d, hsync_d, vsync_d, blank_d} = dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_r <= '0;
            cart_r <= '0;
        end else begin
            edge_r <= rgb_edge;
            cart_r <= rgb_cartoon;
        end
    end

    assign commit   = (hcount_d == '0) && (vcount_d == '0);
    assign req      = sel_valid | mode_next;
    assign req_mode = sel_valid ? mode_t'(sel_mode)
                                : mode_succ((state_q == ST_PEND) ? target_q : mode_q);

    always_comb begin
        state_n  = state_q;
        mode_n   = mode_q;
        target_n = target_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    target_n = req_mode;
                    state_n  = ST_PEND;
                end
            end
            ST_PEND: begin
                // A request landing on the commit cycle re-arms for the next frame.
                if (commit) begin
                    mode_n = target_q;
                    if (!req) state_n = ST_IDLE;
                end
                if (req) target_n = req_mode;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= mode_t'(RESET_MODE);
            target_q <= mode_t'(RESET_MODE);
        end else begin
            state_q  <= state_n;
            mode_q   <= mode_n;
            target_q <= target_n;
        end
    end

    assign border = (hcount_d == '0) || (hcount_d == 11'(H_ACTIVE - 1)) ||
                    (vcount_d == '0) || (vcount_d == 10'(V_ACTIVE - 1));

    // mode_n already carries a same-cycle commit, so the boundary pixel uses the new mode.
    always_comb begin
        rgb_sel = '0;
        if (!blank_d) begin
            if (border && (mode_n != MODE_PASS)) begin
                rgb_sel = rgb_d;
            end else begin
                case (mode_n)
                    MODE_PASS:    rgb_sel = rgb_d;
                    MODE_SKETCH:  rgb_sel = edge_r;
                    MODE_CARTOON: rgb_sel = cart_r;
                    MODE_SPLIT:   rgb_sel = (hcount_d < 11'(H_ACTIVE / 2)) ? cart_r : rgb_d;
                    default:      rgb_sel = rgb_d;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            rgb_out   <= rgb_sel;
            hsync_out <= hsync_d;
            vsync_out <= vsync_d;
            blank_out <= blank_d;
        end
    end

    assign mode    = mode_q;
    assign pending = (state_q == ST_PEND);

endmodule
